// File: rtl/button_reader.sv
// button_reader: synchronises, debounces and classifies NBTN active-low push
// buttons into level, press, release, short-press and long-press events.
// All state advances on a shared prescaled sample tick; everything is
// single-clock with a synchronous active-high reset.
module button_reader #(
    parameter int unsigned NBTN       = 3,
    parameter int unsigned TICK_W     = 17,
    parameter int unsigned DEB_TICKS  = 4,
    parameter int unsigned LONG_TICKS = 400
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NBTN-1:0] BTN_N,
    output logic [NBTN-1:0] BTN_LEVEL,
    output logic [NBTN-1:0] BTN_PRESS,
    output logic [NBTN-1:0] BTN_RELEASE,
    output logic [NBTN-1:0] BTN_SHORT,
    output logic [NBTN-1:0] BTN_LONG,
    output logic            TICK
);

    localparam int unsigned DCNT_W = $clog2(DEB_TICKS + 1);
    localparam int unsigned HCNT_W = $clog2(LONG_TICKS + 1);

    // Prescaler value one cycle before the all-ones count, so TICK can be
    // registered and still be high exactly while the count is all-ones.
    localparam logic [TICK_W-1:0] PRESC_LAST = {TICK_W{1'b1}};
    localparam logic [TICK_W-1:0] PRESC_PRE  = PRESC_LAST - TICK_W'(1);

    localparam logic [DCNT_W-1:0] DEB_LIMIT  = DCNT_W'(DEB_TICKS);
    localparam logic [HCNT_W-1:0] LONG_LIMIT = HCNT_W'(LONG_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
        ST_LONGHELD = 2'd2
    } state_t;

    logic [TICK_W-1:0] presc;
    logic [NBTN-1:0]   sync_a;
    logic [NBTN-1:0]   sync_b;

    // Free-running prescaler with a registered strobe on the all-ones count
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc <= '0;
            TICK  <= 1'b0;
        end else begin
            presc <= presc + TICK_W'(1);
            TICK  <= (presc == PRESC_PRE);
        end
    end

    // Two-flop synchroniser; pins are inverted so 1 means pressed
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= ~BTN_N;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        logic [DCNT_W-1:0] dcnt;
        logic [DCNT_W-1:0] dcnt_inc;
        logic [HCNT_W-1:0] hcnt;
        logic [HCNT_W-1:0] hcnt_inc;
        logic              level;
        logic              mismatch;
        logic              accept;
        logic              rise;
        logic              fall;
        logic              press_q;
        logic              rel_q;
        logic              short_q;
        logic              long_q;
        state_t            state;

        // Decide whether this cycle's tick completes a debounce run
        always_comb begin
            mismatch = sync_b[i] ^ level;
            dcnt_inc = dcnt + DCNT_W'(1);
            hcnt_inc = hcnt + HCNT_W'(1);
            accept   = mismatch && TICK && (dcnt_inc == DEB_LIMIT);
            rise     = accept && !level;
            fall     = accept && level;
        end

        // Debounce counter, debounced level and edge pulses
        always_ff @(posedge CLK) begin
            if (RST) begin
                dcnt    <= '0;
                level   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= rise;
                rel_q   <= fall;
                if (!mismatch) begin
                    dcnt <= '0;
                end else if (TICK) begin
                    if (accept) begin
                        level <= ~level;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt_inc;
                    end
                end
            end
        end

        // Hold classifier: a release always beats a coincident long threshold
        always_ff @(posedge CLK) begin
            if (RST) begin
                state   <= ST_IDLE;
                hcnt    <= '0;
                short_q <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                short_q <= 1'b0;
                long_q  <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_HELD;
                            hcnt  <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (fall) begin
                            state   <= ST_IDLE;
                            short_q <= 1'b1;
                        end else if (TICK) begin
                            hcnt <= hcnt_inc;
                            if (hcnt_inc == LONG_LIMIT) begin
                                state  <= ST_LONGHELD;
                                long_q <= 1'b1;
                            end
                        end
                    end
                    ST_LONGHELD: begin
                        if (fall) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign BTN_LEVEL[i]   = level;
        assign BTN_PRESS[i]   = press_q;
        assign BTN_RELEASE[i] = rel_q;
        assign BTN_SHORT[i]   = short_q;
        assign BTN_LONG[i]    = long_q;
    end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed scenarios plus randomized pin activity,
// with expected events from a tick-counting reference model kept in a queue.
module tb_button_reader;

    localparam int unsigned NBTN   = 3;
    localparam int unsigned TICK_W = 4;
    localparam int          DEB    = 3;
    localparam int          LONG   = 5;
    localparam int          TP     = 16;

    logic            clk;
    logic            rst;
    logic [NBTN-1:0] btn_n;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic [NBTN-1:0] shrt;
    logic [NBTN-1:0] lng;
    logic            tick;

    button_reader #(
        .NBTN      (NBTN),
        .TICK_W    (TICK_W),
        .DEB_TICKS (DEB),
        .LONG_TICKS(LONG)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .BTN_N      (btn_n),
        .BTN_LEVEL  (level),
        .BTN_PRESS  (press),
        .BTN_RELEASE(rel),
        .BTN_SHORT  (shrt),
        .BTN_LONG   (lng),
        .TICK       (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1);
    end

    typedef struct {
        int         cyc;
        logic [11:0] ev;   // {press, release, short, long}
        logic [2:0]  lvl;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model state: tick phase, 2-deep pin history, debounced level,
    // mismatching-tick runs and ticks counted since each press.
    int         pcnt = 0;
    logic       m_tick = 1'b0;
    logic [2:0] m_s1 = '0;
    logic [2:0] m_s2 = '0;
    logic [2:0] m_lvl = '0;
    int         mm_run[NBTN];
    int         held_ticks[NBTN];

    // Observed pulse counts and timestamps
    int n_pr[NBTN];
    int n_rl[NBTN];
    int n_sh[NBTN];
    int n_lg[NBTN];
    int t_pr[NBTN];
    int t_rl[NBTN];
    int t_sh[NBTN];
    int t_lg[NBTN];
    int n_any = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model, evaluated on every rising edge
    always @(posedge clk) begin
        logic [2:0] pr, rl, sh, lg;
        bit tick_now;
        cyc++;
        pr = '0; rl = '0; sh = '0; lg = '0;
        if (rst) begin
            pcnt   = 0;
            m_tick = 1'b0;
            m_s1   = '0;
            m_s2   = '0;
            m_lvl  = '0;
            for (int i = 0; i < NBTN; i++) begin
                mm_run[i]     = 0;
                held_ticks[i] = 0;
            end
        end else begin
            tick_now = (pcnt == TP - 1);
            pcnt     = (pcnt + 1) % TP;
            for (int i = 0; i < NBTN; i++) begin
                if (m_s2[i] == m_lvl[i]) begin
                    mm_run[i] = 0;
                end else if (tick_now) begin
                    mm_run[i]++;
                    if (mm_run[i] == DEB) begin
                        mm_run[i] = 0;
                        m_lvl[i]  = ~m_lvl[i];
                        if (m_lvl[i]) pr[i] = 1'b1;
                        else          rl[i] = 1'b1;
                    end
                end
                if (pr[i]) begin
                    held_ticks[i] = 0;
                end else if (rl[i]) begin
                    if (held_ticks[i] < LONG) sh[i] = 1'b1;
                end else if (m_lvl[i] && tick_now) begin
                    held_ticks[i]++;
                    if (held_ticks[i] == LONG) lg[i] = 1'b1;
                end
            end
            m_s2   = m_s1;
            m_s1   = ~btn_n;
            m_tick = (pcnt == TP - 1);
            if ({pr, rl, sh, lg} != 12'h0)
                sb.push_back('{cyc: cyc, ev: {pr, rl, sh, lg}, lvl: m_lvl});
        end
    end

    // Monitor: compares tick/level every cycle and pops expected events
    always @(negedge clk) begin
        logic [11:0] dev;
        exp_t e;
        dev = {press, rel, shrt, lng};
        chk("tick", 32'(tick), 32'(m_tick));
        chk("level", 32'(level), 32'(m_lvl));
        if (dev != 12'h0) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'(dev), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                chk("event_vector", 32'(dev), 32'(e.ev));
                chk("event_level", 32'(level), 32'(e.lvl));
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missed_event", 32'(dev), 32'(e.ev));
        end
        n_any += $countones(dev);
        for (int i = 0; i < NBTN; i++) begin
            if (press[i]) begin n_pr[i]++; t_pr[i] = cyc; end
            if (rel[i])   begin n_rl[i]++; t_rl[i] = cyc; end
            if (shrt[i])  begin n_sh[i]++; t_sh[i] = cyc; end
            if (lng[i])   begin n_lg[i]++; t_lg[i] = cyc; end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_press(input int b, input int budget);
        int start;
        int k;
        start = n_pr[b];
        k = 0;
        while (n_pr[b] == start && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("press_seen_%0d", b), 32'(n_pr[b] - start), 32'd1);
    endtask

    initial begin
        int c0;
        int first;
        int b_pr, b_rl, b_sh, b_lg, b_any, b_sh2, b_lg2;
        int tk;
        int guard;
        int hold_left[NBTN];

        for (int i = 0; i < NBTN; i++) begin
            n_pr[i] = 0; n_rl[i] = 0; n_sh[i] = 0; n_lg[i] = 0;
            t_pr[i] = 0; t_rl[i] = 0; t_sh[i] = 0; t_lg[i] = 0;
            hold_left[i] = 0;
        end
        rst   = 1'b1;
        btn_n = '1;

        // 1: reset state and first tick position
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs", 32'({level, press, rel, shrt, lng, tick}), 32'h0);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (tick) begin
                first = k;
                break;
            end
        end
        chk("first_tick_cycle", 32'(first), 32'd15);

        // 2: clean short press on button 0
        b_rl = n_rl[0]; b_sh = n_sh[0]; b_lg = n_lg[0];
        btn_n[0] = 1'b0;
        c0 = cyc;
        wait_press(0, 100);
        chk("s2_press_latency_ok", 32'((t_pr[0] - c0) <= 3 * TP + 3), 32'd1);
        chk("s2_level_after_press", 32'(level[0]), 32'd1);
        while (cyc - c0 < 4 * TP) step();
        btn_n[0] = 1'b1;
        repeat (80) step();
        chk("s2_release_count", 32'(n_rl[0] - b_rl), 32'd1);
        chk("s2_short_count", 32'(n_sh[0] - b_sh), 32'd1);
        chk("s2_long_count", 32'(n_lg[0] - b_lg), 32'd0);
        chk("s2_release_short_same_cycle", 32'(t_sh[0]), 32'(t_rl[0]));

        // 3: bouncing pin, then stable press
        b_any = n_any;
        b_pr  = n_pr[0];
        for (int k = 0; k < 24; k++) begin
            btn_n[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (5) step();
        end
        chk("s3_no_pulse_during_bounce", 32'(n_any - b_any), 32'd0);
        btn_n[0] = 1'b0;
        repeat (80) step();
        chk("s3_single_press", 32'(n_pr[0] - b_pr), 32'd1);
        btn_n[0] = 1'b1;
        repeat (100) step();

        // 4: long press on button 1
        b_rl = n_rl[1]; b_sh = n_sh[1]; b_lg = n_lg[1];
        btn_n[1] = 1'b0;
        c0 = cyc;
        wait_press(1, 100);
        while (cyc - c0 < 12 * TP) step();
        chk("s4_long_once", 32'(n_lg[1] - b_lg), 32'd1);
        chk("s4_long_delay", 32'(t_lg[1] - t_pr[1]), 32'(5 * TP));
        btn_n[1] = 1'b1;
        repeat (80) step();
        chk("s4_release_count", 32'(n_rl[1] - b_rl), 32'd1);
        chk("s4_no_short", 32'(n_sh[1] - b_sh), 32'd0);
        chk("s4_no_repeat_long", 32'(n_lg[1] - b_lg), 32'd1);

        // 5: simultaneous presses; release lands on the long threshold tick
        b_pr = n_pr[2]; b_sh = n_sh[0]; b_sh2 = n_sh[2]; b_lg = n_lg[0]; b_lg2 = n_lg[2];
        btn_n[0] = 1'b0;
        btn_n[2] = 1'b0;
        wait_press(0, 100);
        chk("s5_press2_count", 32'(n_pr[2] - b_pr), 32'd1);
        chk("s5_press_same_cycle", 32'(t_pr[2]), 32'(t_pr[0]));
        repeat (2 * TP) step();
        btn_n[0] = 1'b1;
        btn_n[2] = 1'b1;
        repeat (80) step();
        chk("s5_short0", 32'(n_sh[0] - b_sh), 32'd1);
        chk("s5_short2", 32'(n_sh[2] - b_sh2), 32'd1);
        chk("s5_no_long0", 32'(n_lg[0] - b_lg), 32'd0);
        chk("s5_no_long2", 32'(n_lg[2] - b_lg2), 32'd0);

        // 6: reset while held, then fresh press
        btn_n[0] = 1'b0;
        wait_press(0, 100);
        tk = 0;
        guard = 0;
        while (tk < 3 && guard < 100) begin
            step();
            guard++;
            if (tick) tk++;
        end
        chk("s6_ticks_seen", 32'(tk), 32'd3);
        b_any = n_any;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_outputs_after_reset", 32'({level, press, rel, shrt, lng}), 32'h0);
        wait_press(0, 100);
        chk("s6_only_fresh_press", 32'(n_any - b_any), 32'd1);
        btn_n[0] = 1'b1;
        repeat (100) step();

        // Random pin activity with occasional resets
        for (int k = 0; k < 4000; k++) begin
            step();
            for (int i = 0; i < NBTN; i++) begin
                if (hold_left[i] == 0) begin
                    btn_n[i] = ~btn_n[i];
                    case ($urandom_range(0, 2))
                        0:       hold_left[i] = $urandom_range(1, 12);
                        1:       hold_left[i] = $urandom_range(20, 70);
                        default: hold_left[i] = $urandom_range(60, 220);
                    endcase
                end else begin
                    hold_left[i]--;
                end
            end
            rst = ($urandom_range(0, 799) == 0);
        end

        rst   = 1'b0;
        btn_n = '1;
        repeat (200) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
